// File: rtl/regfile_scoreboard_if.sv
// Issue / writeback / read bundle between decode and the register-file scoreboard.
// master = decode side, slave = regfile_scoreboard.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 16
);
    logic              issue_valid;
    logic              issue_wen;
    logic [3:0]        issue_dst;
    logic [3:0]        src1;
    logic [3:0]        src2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              issue_ready;
    logic              wb_valid;
    logic [3:0]        wb_dst;
    logic [DATA_W-1:0] wb_data;
    logic [15:0]       busy_vec;
    logic              wb_err;

    modport master (
        output issue_valid, issue_wen, issue_dst, src1, src2,
        output wb_valid, wb_dst, wb_data,
        input  rd1, rd2, issue_ready, busy_vec, wb_err
    );

    modport slave (
        input  issue_valid, issue_wen, issue_dst, src1, src2,
        input  wb_valid, wb_dst, wb_data,
        output rd1, rd2, issue_ready, busy_vec, wb_err
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// 16-entry register file with per-register pending-write counters that gate
// instruction issue on RAW hazards and on counter saturation.
// Optional macro REGFILE_BYPASS_EN: forwards writeback data to reads and lets
// a source whose last pending write is retiring this cycle count as not busy.
module regfile_scoreboard #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_scoreboard_if.slave   bus
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [15:0][DATA_W-1:0] regs_q, regs_d;
    logic [15:0][1:0]        pend_q, pend_d;
    logic                    err_q,  err_d;
    logic                    ready;
    logic                    accept;
    logic                    wb_act;

    // A source is busy while writes are pending, unless the single remaining
    // write is retiring right now and its data can be forwarded.
    function automatic logic src_busy(input logic [3:0] idx);
        logic relief;
        relief = BYPASS && bus.wb_valid && (bus.wb_dst == idx) && (pend_q[idx] == 2'd1);
        return (pend_q[idx] != 2'd0) && !relief;
    endfunction

    // R0 reads as zero; forwarding path only exists with bypass enabled.
    function automatic logic [DATA_W-1:0] rd_sel(input logic [3:0] idx);
        if (idx == 4'd0)
            return '0;
        else if (BYPASS && bus.wb_valid && (bus.wb_dst == idx))
            return bus.wb_data;
        else
            return regs_q[idx];
    endfunction

    // Combinational read ports, hazard check and status outputs.
    always_comb begin
        ready = bus.issue_valid
             && !src_busy(bus.src1)
             && !src_busy(bus.src2)
             && !(bus.issue_wen && (bus.issue_dst != 4'd0) && (pend_q[bus.issue_dst] == 2'd3));
        bus.issue_ready = ready;
        bus.rd1         = rd_sel(bus.src1);
        bus.rd2         = rd_sel(bus.src2);
        bus.wb_err      = err_q;
        for (int i = 0; i < 16; i++)
            bus.busy_vec[i] = (pend_q[i] != 2'd0);
    end

    // Next state: counter inc/dec (cancelling when both hit one register),
    // register write, sticky error on writeback without a pending write.
    always_comb begin
        pend_d = pend_q;
        regs_d = regs_q;
        err_d  = err_q;
        accept = ready && bus.issue_wen && (bus.issue_dst != 4'd0);
        wb_act = bus.wb_valid && (bus.wb_dst != 4'd0);
        for (int i = 1; i < 16; i++) begin
            logic inc, dec;
            inc = accept && (bus.issue_dst == 4'(i));
            dec = wb_act && (bus.wb_dst == 4'(i)) && (pend_q[i] != 2'd0);
            if (inc && !dec)
                pend_d[i] = pend_q[i] + 2'd1;
            else if (dec && !inc)
                pend_d[i] = pend_q[i] - 2'd1;
        end
        pend_d[0] = 2'd0;
        if (wb_act) begin
            regs_d[bus.wb_dst] = bus.wb_data;
            if (pend_q[bus.wb_dst] == 2'd0)
                err_d = 1'b1;
        end
        regs_d[0] = '0;
    end

    // State registers; reset wins over any same-cycle issue or writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

endmodule
